// File: rtl/bus_sram_target.sv
// bus_sram_target: request/ready bus responder backed by a byte-maskable word array
module bus_sram_target #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SIZE_WORDS    = 1024,
  parameter int LATENCY       = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_stall,
  output logic                     o_busy,
  input  logic                     i_rw,
  input  logic                     i_request,
  output logic                     o_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  output logic [31:0]              o_rdata,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wmask
);
  localparam int IW = $clog2(SIZE_WORDS);
  typedef enum logic [1:0] {IDLE, ACCESS, READY, RELEASE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic rw_q;
  logic [IW-1:0] idx;
  logic [31:0] wdata_q;
  logic [3:0] wmask_q;
  logic [31:0] mem [SIZE_WORDS];
  logic commit;
  logic unused_addr;
  assign unused_addr = ^{i_address[ADDRESS_WIDTH-1:IW+2], i_address[1:0]};
  assign commit = state == ACCESS && !i_stall && cnt == 4'd1;
  assign o_ready = state == READY;
  assign o_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_request ? ACCESS : IDLE;
      ACCESS:  state_nx = commit ? READY : ACCESS;
      READY:   state_nx = RELEASE;
      RELEASE: state_nx = i_request ? RELEASE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      o_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_request) begin
        rw_q    <= i_rw;
        idx     <= i_address[IW+1:2];
        wdata_q <= i_wdata;
        wmask_q <= i_wmask;
        cnt     <= 4'(LATENCY);
      end else if (state == ACCESS && !i_stall && cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !rw_q) o_rdata <= mem[idx];
    end
  end
  // Array is deliberately not reset; a reset landing on the commit edge drops the write
  always_ff @(posedge i_clock)
    for (int n = 0; n < 4; n++)
      if (i_reset && commit && rw_q && wmask_q[n]) mem[idx][8*n +: 8] <= wdata_q[8*n +: 8];
endmodule

// File: tb/tb_bus_sram_target.sv
// tb_bus_sram_target: directed checks on a LATENCY=1 and a LATENCY=4 instance
module tb_bus_sram_target;
  logic clk = 0;
  logic rst = 0;
  logic stall = 0, rw = 0, req1 = 0, req4 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wmask = 0;
  logic rdy1, busy1, rdy4, busy4;
  logic [31:0] rd1, rd4, rd;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bus_sram_target #(.LATENCY(1)) u_l1 (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .o_busy(busy1), .i_rw(rw),
    .i_request(req1), .o_ready(rdy1), .i_address(addr), .o_rdata(rd1),
    .i_wdata(wdata), .i_wmask(wmask));

  bus_sram_target #(.LATENCY(4)) u_l4 (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .o_busy(busy4), .i_rw(rw),
    .i_request(req4), .o_ready(rdy4), .i_address(addr), .o_rdata(rd4),
    .i_wdata(wdata), .i_wmask(wmask));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit w4, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input int nst, input int hold, output logic [31:0] q);
    int n;
    @(negedge clk);
    rw = wr; addr = a; wdata = d; wmask = m;
    if (w4) req4 = 1; else req1 = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      stall = (n <= nst);
    end while (!(w4 ? rdy4 : rdy1) && n < 40);
    stall = 0;
    chk("latency", n, (w4 ? 4 : 1) + 1 + nst);
    q = w4 ? rd4 : rd1;
    rw = ~wr; addr = '1; wdata = '1; wmask = '1;
    repeat (hold) begin
      @(negedge clk);
      chk("no_second_ready", 32'(w4 ? rdy4 : rdy1), 0);
      chk("busy_while_held", 32'(w4 ? busy4 : busy1), 1);
    end
    req1 = 0; req4 = 0;
    @(negedge clk);
    chk("single_pulse", 32'(w4 ? rdy4 : rdy1), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1;
    chk("rst_ready1", 32'(rdy1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_ready4", 32'(rdy4), 0);
    chk("rst_rdata4", rd4, 0);

    txn(0, 1, 32'h10, 32'h12345678, 4'hF, 0, 0, rd);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 0, rd);
    chk("basic_read", rd, 32'h12345678);

    txn(0, 1, 32'h14, 32'hAABBCCDD, 4'hF, 0, 0, rd);
    txn(0, 1, 32'h14, 32'h11223344, 4'b0101, 0, 0, rd);
    txn(0, 0, 32'h14, 32'h0, 4'h0, 0, 0, rd);
    chk("byte_mask", rd, 32'hAA22CC44);
    txn(0, 1, 32'h14, 32'hFFFFFFFF, 4'h0, 0, 0, rd);
    chk("rdata_kept_on_write", rd1, 32'hAA22CC44);
    txn(0, 0, 32'h14, 32'h0, 4'h0, 0, 0, rd);
    chk("mask_zero", rd, 32'hAA22CC44);

    txn(0, 1, 32'h4, 32'hCAFEF00D, 4'hF, 0, 0, rd);
    txn(0, 0, 32'h1004, 32'h0, 4'h0, 0, 0, rd);
    chk("alias_1004", rd, 32'hCAFEF00D);
    txn(0, 0, 32'h1007, 32'h0, 4'h0, 0, 0, rd);
    chk("alias_1007", rd, 32'hCAFEF00D);

    txn(0, 0, 32'h10, 32'h0, 4'h0, 0, 3, rd);
    chk("held_read", rd, 32'h12345678);
    txn(0, 0, 32'h4, 32'h0, 4'h0, 0, 0, rd);
    chk("after_hold", rd, 32'hCAFEF00D);

    txn(1, 1, 32'h8, 32'h55AA55AA, 4'hF, 3, 0, rd);
    txn(1, 0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
    chk("stalled_write", rd, 32'h55AA55AA);

    txn(1, 1, 32'h20, 32'h0, 4'hF, 0, 0, rd);
    txn(1, 0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
    @(negedge clk);
    rw = 1; addr = 32'h20; wdata = 32'hDEADBEEF; wmask = 4'hF; req4 = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_ready", 32'(rdy4), 0);
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_rdata", rd4, 0);
    rst = 1; req4 = 0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(rdy4), 0);
    end
    txn(1, 0, 32'h20, 32'h0, 4'h0, 0, 0, rd);
    chk("abort_not_written", rd, 32'h0);
    txn(1, 0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
    chk("committed_persists", rd, 32'h55AA55AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
